// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU pixel path.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

package gpu_pkg;

    localparam int unsigned PIX_WIDTH_BITS   = `WIDTH_BITS;
    localparam int unsigned PIX_HEIGHT_BITS  = `HEIGHT_BITS;
    localparam int unsigned PIX_CHANNEL_BITS = `CHANNEL_BITS;

    // Arbitration modes
    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // One pixel as produced by a drawing engine
    typedef struct packed {
        logic [`WIDTH_BITS-1:0]   x;
        logic [`HEIGHT_BITS-1:0]  y;
        logic [`CHANNEL_BITS-1:0] r;
        logic [`CHANNEL_BITS-1:0] g;
        logic [`CHANNEL_BITS-1:0] b;
    } pixel_t;

    // Grant lock state: idle, or holding one source until its last pixel
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Show-ahead FIFO: head entry drives head_data directly, zero when empty.
module gpu_pixel_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  logic [DATA_BITS-1:0]   push_data,
    input  logic                   pop,
    output logic [DATA_BITS-1:0]   head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS-1:0]  rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CNT_BITS'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO never accepts, even when it pops in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy tracking; power-of-two depth wraps naturally
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/gpu_pixel_arbiter.sv
// Arbitrates NUM_SRC pixel engines onto one buffered pixel stream, keeping
// each primitive's pixels contiguous via a grant lock.
module gpu_pixel_arbiter
    import gpu_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned ARB_MODE     = ARB_FIXED,
    parameter int unsigned WIDTH_BITS   = PIX_WIDTH_BITS,
    parameter int unsigned HEIGHT_BITS  = PIX_HEIGHT_BITS,
    parameter int unsigned CHANNEL_BITS = PIX_CHANNEL_BITS,
    localparam int unsigned ID_BITS     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC-1:0]              src_last,
    input  logic [NUM_SRC*WIDTH_BITS-1:0]   src_x,
    input  logic [NUM_SRC*HEIGHT_BITS-1:0]  src_y,
    input  logic [NUM_SRC*CHANNEL_BITS-1:0] src_r,
    input  logic [NUM_SRC*CHANNEL_BITS-1:0] src_g,
    input  logic [NUM_SRC*CHANNEL_BITS-1:0] src_b,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH_BITS-1:0]           x_o,
    output logic [HEIGHT_BITS-1:0]          y_o,
    output logic [CHANNEL_BITS-1:0]         r_o,
    output logic [CHANNEL_BITS-1:0]         g_o,
    output logic [CHANNEL_BITS-1:0]         b_o,
    output logic [ID_BITS-1:0]              src_id_o,
    output logic                            busy
);

    localparam int unsigned PAY_BITS = WIDTH_BITS + HEIGHT_BITS + 3 * CHANNEL_BITS + ID_BITS;
    localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    arb_state_t                state_q;
    arb_state_t                state_d;
    logic                      lock_valid;
    logic [ID_BITS-1:0]        lock_id;
    logic [ID_BITS-1:0]        rr_ptr;
    logic [ID_BITS-1:0]        rr_idx;
    logic                      sel_found;

    logic [NUM_SRC-1:0]        grant;
    logic [NUM_SRC-1:0]        accept;
    logic                      acc_any;
    logic [ID_BITS-1:0]        sel_id;
    logic                      sel_last;
    logic [WIDTH_BITS-1:0]     sel_x;
    logic [HEIGHT_BITS-1:0]    sel_y;
    logic [CHANNEL_BITS-1:0]   sel_r;
    logic [CHANNEL_BITS-1:0]   sel_g;
    logic [CHANNEL_BITS-1:0]   sel_b;

    logic [PAY_BITS-1:0]       push_data;
    logic [PAY_BITS-1:0]       head_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_BITS-1:0]       fifo_count;

    // Lock state register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock next state: any accept decides from its last flag
    always_comb begin
        state_d = state_q;
        if (acc_any) begin
            state_d = sel_last ? ST_IDLE : ST_LOCKED;
        end
    end

    // Lock outputs
    always_comb begin
        lock_valid = (state_q == ST_LOCKED);
    end

    // Locked source identity and round-robin pointer, both follow the accept
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            lock_id <= '0;
            rr_ptr  <= '0;
        end else if (acc_any) begin
            lock_id <= sel_id;
            rr_ptr  <= (sel_id == ID_BITS'(NUM_SRC - 1)) ? '0 : sel_id + ID_BITS'(1);
        end
    end

    // Grant selection: lock wins, else fixed priority or round-robin search
    always_comb begin
        grant     = '0;
        sel_id    = '0;
        sel_found = 1'b0;
        rr_idx    = '0;
        if (lock_valid) begin
            grant[lock_id] = 1'b1;
            sel_id         = lock_id;
        end else if (ARB_MODE == ARB_FIXED) begin
            for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
                if (src_valid[k]) begin
                    grant    = '0;
                    grant[k] = 1'b1;
                    sel_id   = ID_BITS'(k);
                end
            end
        end else begin
            for (int k = 0; k < int'(NUM_SRC); k++) begin
                rr_idx = ID_BITS'((int'(rr_ptr) + k) % int'(NUM_SRC));
                if (!sel_found && src_valid[rr_idx]) begin
                    grant[rr_idx] = 1'b1;
                    sel_id        = rr_idx;
                    sel_found     = 1'b1;
                end
            end
        end
    end

    // Payload mux for the granted source
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_r = '0;
        sel_g = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (grant[i]) begin
                sel_x = src_x[i*WIDTH_BITS   +: WIDTH_BITS];
                sel_y = src_y[i*HEIGHT_BITS  +: HEIGHT_BITS];
                sel_r = src_r[i*CHANNEL_BITS +: CHANNEL_BITS];
                sel_g = src_g[i*CHANNEL_BITS +: CHANNEL_BITS];
                sel_b = src_b[i*CHANNEL_BITS +: CHANNEL_BITS];
            end
        end
    end

    assign sel_last  = src_last[sel_id];
    assign src_ready = grant & {NUM_SRC{!fifo_full}};
    assign accept    = src_valid & src_ready;
    assign acc_any   = |accept;
    assign push_data = {sel_x, sel_y, sel_r, sel_g, sel_b, sel_id};

    gpu_pixel_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .DATA_BITS (PAY_BITS)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (acc_any),
        .push_data (push_data),
        .pop       (out_ready),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {x_o, y_o, r_o, g_o, b_o, src_id_o} = head_data;
    assign out_valid = !fifo_empty;
    assign busy      = (fifo_count != '0) || lock_valid;

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Scoreboard bench: dut0 is 2-source fixed priority, dut1 is 3-source round-robin.
module tb_gpu_pixel_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: NUM_SRC=2, ARB_MODE=0, FIFO_DEPTH=4
    logic        rst0;
    logic [1:0]  v0, l0, rdy0;
    logic [19:0] x0s, y0s;
    logic [15:0] r0s, g0s, b0s;
    logic        ov0, or0, id0, busy0;
    logic [9:0]  xo0, yo0;
    logic [7:0]  ro0, go0, bo0;

    // dut1: NUM_SRC=3, ARB_MODE=1, FIFO_DEPTH=4
    logic        rst1;
    logic [2:0]  v1, l1, rdy1;
    logic [29:0] x1s, y1s;
    logic [23:0] r1s, g1s, b1s;
    logic        ov1, or1, busy1;
    logic [1:0]  id1;
    logic [9:0]  xo1, yo1;
    logic [7:0]  ro1, go1, bo1;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    gpu_pixel_arbiter #(.NUM_SRC(2), .FIFO_DEPTH(4), .ARB_MODE(0),
                        .WIDTH_BITS(10), .HEIGHT_BITS(10), .CHANNEL_BITS(8)) dut0 (
        .clk(clk), .n_rst(rst0), .src_valid(v0), .src_last(l0),
        .src_x(x0s), .src_y(y0s), .src_r(r0s), .src_g(g0s), .src_b(b0s),
        .src_ready(rdy0), .out_valid(ov0), .out_ready(or0),
        .x_o(xo0), .y_o(yo0), .r_o(ro0), .g_o(go0), .b_o(bo0),
        .src_id_o(id0), .busy(busy0));

    gpu_pixel_arbiter #(.NUM_SRC(3), .FIFO_DEPTH(4), .ARB_MODE(1),
                        .WIDTH_BITS(10), .HEIGHT_BITS(10), .CHANNEL_BITS(8)) dut1 (
        .clk(clk), .n_rst(rst1), .src_valid(v1), .src_last(l1),
        .src_x(x1s), .src_y(y1s), .src_r(r1s), .src_g(g1s), .src_b(b1s),
        .src_ready(rdy1), .out_valid(ov1), .out_ready(or1),
        .x_o(xo1), .y_o(yo1), .r_o(ro1), .g_o(go1), .b_o(bo1),
        .src_id_o(id1), .busy(busy1));

    function automatic logic [63:0] pk(input int x, input int y, input int r,
                                       input int g, input int b, input int id);
        return 64'({10'(x), 10'(y), 8'(r), 8'(g), 8'(b), 2'(id)});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set0(input int i, input logic v, input logic last, input int x,
                        input int y, input int r, input int g, input int b);
        v0[i] = v;
        l0[i] = last;
        x0s[i*10 +: 10] = 10'(x);
        y0s[i*10 +: 10] = 10'(y);
        r0s[i*8 +: 8]   = 8'(r);
        g0s[i*8 +: 8]   = 8'(g);
        b0s[i*8 +: 8]   = 8'(b);
    endtask

    task automatic set1(input int i, input logic v, input int x, input int y,
                        input int r, input int g, input int b);
        v1[i] = v;
        l1[i] = 1'b1;
        x1s[i*10 +: 10] = 10'(x);
        y1s[i*10 +: 10] = 10'(y);
        r1s[i*8 +: 8]   = 8'(r);
        g1s[i*8 +: 8]   = 8'(g);
        b1s[i*8 +: 8]   = 8'(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor dut0: every pop is compared against the scoreboard head
    always @(negedge clk) begin
        if (ov0 === 1'b1 && or0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out0_unexpected: got %0h want none",
                         64'({xo0, yo0, ro0, go0, bo0, 2'(id0)}));
            end else begin
                chk("out0_pixel", 64'({xo0, yo0, ro0, go0, bo0, 2'(id0)}), q0.pop_front());
            end
        end
    end

    // Monitor dut1
    always @(negedge clk) begin
        if (ov1 === 1'b1 && or1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out1_unexpected: got %0h want none",
                         64'({xo1, yo1, ro1, go1, bo1, id1}));
            end else begin
                chk("out1_pixel", 64'({xo1, yo1, ro1, go1, bo1, id1}), q1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int drain;
        rst0 = 1'b0; rst1 = 1'b0;
        v0 = '0; l0 = '0; x0s = '0; y0s = '0; r0s = '0; g0s = '0; b0s = '0;
        v1 = '0; l1 = '0; x1s = '0; y1s = '0; r1s = '0; g1s = '0; b1s = '0;
        or0 = 1'b0; or1 = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        chk("rst_out_valid0", 64'(ov0), 64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_data0", 64'({xo0, yo0, ro0, go0, bo0, id0}), 64'd0);
        chk("rst_ready0", 64'(rdy0), 64'd0);
        chk("rst_out_valid1", 64'(ov1), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_ready1", 64'(rdy1), 64'd0);

        // Fixed priority: both valid, src0 wins, src1 follows
        step();
        or0 = 1'b1;
        set0(0, 1'b1, 1'b1, 5, 7, 1, 2, 3);
        set0(1, 1'b1, 1'b1, 20, 21, 4, 5, 6);
        q0.push_back(pk(5, 7, 1, 2, 3, 0));
        q0.push_back(pk(20, 21, 4, 5, 6, 1));
        @(negedge clk);
        chk("fp_ready_first", 64'(rdy0), 64'd1);
        chk("fp_empty_same_cycle", 64'(ov0), 64'd0);
        step();
        v0[0] = 1'b0;
        @(negedge clk);
        chk("fp_ready_second", 64'(rdy0), 64'd2);
        chk("fp_head_valid", 64'(ov0), 64'd1);
        chk("fp_head_id", 64'(id0), 64'd0);
        chk("fp_head_x", 64'(xo0), 64'd5);
        step();
        v0[1] = 1'b0;
        @(negedge clk);
        chk("fp_second_id", 64'(id0), 64'd1);
        repeat (3) step();

        // Lock: src1 primitive of three with a valid gap; src0 waits
        set0(1, 1'b1, 1'b0, 30, 31, 7, 8, 9);
        q0.push_back(pk(30, 31, 7, 8, 9, 1));
        @(negedge clk);
        chk("lock_first", 64'(rdy0), 64'd2);
        step();
        v0[1] = 1'b0;
        set0(0, 1'b1, 1'b1, 40, 41, 10, 11, 12);
        @(negedge clk);
        chk("lock_gap_hold", 64'(rdy0), 64'd2);
        chk("lock_busy", 64'(busy0), 64'd1);
        step();
        set0(1, 1'b1, 1'b0, 32, 33, 7, 8, 9);
        q0.push_back(pk(32, 33, 7, 8, 9, 1));
        @(negedge clk);
        chk("lock_second", 64'(rdy0), 64'd2);
        step();
        set0(1, 1'b1, 1'b1, 34, 35, 7, 8, 9);
        q0.push_back(pk(34, 35, 7, 8, 9, 1));
        @(negedge clk);
        chk("lock_third", 64'(rdy0), 64'd2);
        step();
        v0[1] = 1'b0;
        q0.push_back(pk(40, 41, 10, 11, 12, 0));
        @(negedge clk);
        chk("lock_released", 64'(rdy0), 64'd1);
        step();
        v0[0] = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("lock_drained_busy", 64'(busy0), 64'd0);

        // Backpressure: fill 4 entries with out_ready low
        step();
        or0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            p = (k < 4) ? k : 4;
            set0(0, 1'b1, 1'b1, 50 + p, 60 + p, p, p + 1, p + 2);
            if (k < 4) q0.push_back(pk(50 + p, 60 + p, p, p + 1, p + 2, 0));
            @(negedge clk);
            chk("bp_ready", 64'(rdy0), (k < 4) ? 64'd1 : 64'd0);
            if (k > 0) begin
                chk("bp_stall_valid", 64'(ov0), 64'd1);
                chk("bp_stall_data", 64'({xo0, yo0, ro0, go0, bo0, id0}),
                    64'({10'd50, 10'd60, 8'd0, 8'd1, 8'd2, 1'b0}));
            end
        end
        step();
        or0 = 1'b1;
        @(negedge clk);
        chk("bp_full_pop_ready", 64'(rdy0), 64'd0);
        step();
        q0.push_back(pk(54, 64, 4, 5, 6, 0));
        @(negedge clk);
        chk("bp_after_pop_ready", 64'(rdy0), 64'd1);
        step();
        v0[0] = 1'b0;
        repeat (8) step();

        // Mid-primitive reset with two locked entries queued
        or0 = 1'b0;
        set0(1, 1'b1, 1'b0, 70, 71, 1, 1, 1);
        @(negedge clk);
        chk("mr_lock_a", 64'(rdy0), 64'd2);
        step();
        set0(1, 1'b1, 1'b0, 72, 73, 1, 1, 1);
        @(negedge clk);
        chk("mr_lock_b", 64'(rdy0), 64'd2);
        step();
        rst0 = 1'b0;
        set0(0, 1'b1, 1'b1, 80, 81, 2, 3, 4);
        @(negedge clk);
        chk("mr_pre_valid", 64'(ov0), 64'd1);
        step();
        rst0 = 1'b1;
        q0.push_back(pk(80, 81, 2, 3, 4, 0));
        @(negedge clk);
        chk("mr_out_valid", 64'(ov0), 64'd0);
        chk("mr_busy", 64'(busy0), 64'd0);
        chk("mr_src0_granted", 64'(rdy0), 64'd1);
        step();
        v0 = '0;
        or0 = 1'b1;

        // Round-robin on dut1: all three valid, grants rotate 0,1,2,0,1,2
        or1 = 1'b1;
        for (int s = 0; s < 3; s++) set1(s, 1'b1, 100 + s, 110 + s, s + 1, s + 2, s + 3);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            p = k % 3;
            q1.push_back(pk(100 + p, 110 + p, p + 1, p + 2, p + 3, p));
            @(negedge clk);
            chk("rr_grant", 64'(rdy1), 64'(3'b001 << p));
        end
        step();
        v1 = '0;

        // Bounded drain of both scoreboards
        drain = 0;
        while ((q0.size() != 0 || q1.size() != 0 || ov0 || ov1) && drain < 50) begin
            step();
            drain++;
        end
        @(negedge clk);
        chk("end_q0_empty", 64'(q0.size()), 64'd0);
        chk("end_q1_empty", 64'(q1.size()), 64'd0);
        chk("end_out_valid0", 64'(ov0), 64'd0);
        chk("end_busy1", 64'(busy1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
